// File: rtl/nn_pkg.sv
// Shared constants and types for the bias path of the layer datapath.
// Widths here are the parameter defaults for the bias ROM/RAM blocks.
package nn_pkg;
    localparam int BIAS_W   = 8;
    localparam int N_BIASES = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } loader_state_e;
endpackage

// File: rtl/bias_ram.sv
// 1W/1R synchronous bias RAM; read data registered, out-of-range reads return 0.
// Latency 1 cycle, read-before-write on address collision; no backpressure.
// Only the output register is reset, array contents are undefined until written.
module bias_ram
    import nn_pkg::*;
#(
    parameter int DEPTH  = N_BIASES,
    parameter int WIDTH  = BIAS_W,
    parameter int ADDR_W = 10,
    parameter int WA_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              wr_en_i,
    input  logic [WA_W-1:0]   wr_addr_i,
    input  logic [WIDTH-1:0]  wr_dat_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_dat_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_dat_d;
    logic [WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    always_comb begin
        rd_dat_d = '0;
        if (rd_addr_i < ADDR_W'(DEPTH)) begin
            rd_dat_d = mem_q[rd_addr_i[WA_W-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/bias_loader.sv
// Run-time bias loader: streams DEPTH bytes into bias_ram after start_i, serves 1-cycle reads.
// Latency: ready_o one cycle after start, done_o one cycle after the last handshake.
// Backpressure: ready_o is a registered state flag; valid_i stalls are absorbed indefinitely.
// Optional BIAS_LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte and err_o.
module bias_loader
    import nn_pkg::*;
#(
    parameter int DEPTH  = N_BIASES,
    parameter int WIDTH  = BIAS_W,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              err_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  bias_o
);
    localparam int WA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    loader_state_e   state_q, state_d;
    logic [WA_W-1:0] wr_addr_q, wr_addr_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            hs;
    logic            wr_en;
    logic            last_wr;
    logic            restart;

    assign hs      = valid_i & ready_q;
    assign wr_en   = hs && (state_q == LOAD);
    assign last_wr = (wr_addr_q == WA_W'(DEPTH - 1));
    assign restart = start_i && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = LOAD;
                    wr_addr_d = '0;
                end
            end
            LOAD: begin
                if (hs) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (last_wr) begin
`ifdef BIAS_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            CHECK: begin
                if (hs) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flags are registered from the next state so they never see valid_i combinationally.
    always_comb begin
        ready_d = (state_d == LOAD) || (state_d == CHECK);
        done_d  = (state_d == DONE);
    end

`ifdef BIAS_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             err_q, err_d;

    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (restart) begin
            sum_d = '0;
            err_d = 1'b0;
        end else if (wr_en) begin
            sum_d = sum_q + data_i;
        end else if (hs && (state_q == CHECK)) begin
            err_d = (data_i != sum_q);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign ready_o = ready_q;
    assign done_o  = done_q;

    bias_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .WA_W   (WA_W)
    ) u_ram (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr_q),
        .wr_dat_i  (data_i),
        .rd_addr_i (rd_addr_i),
        .rd_dat_o  (bias_o)
    );
endmodule

// File: tb/tb_bias_loader.sv
// Self-checking bench for bias_loader against an array model of the bias RAM and load protocol.
// Works with or without BIAS_LOADER_CHECKSUM_EN defined.
module tb_bias_loader;
    localparam int DEPTH = 10;
`ifdef BIAS_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int NBYTES = CSUM ? DEPTH + 1 : DEPTH;

    typedef logic [7:0] blk_t [DEPTH+1];

    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o, done_o, err_o;
    logic [9:0] rd_addr_i = '0;
    logic [7:0] bias_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] model [DEPTH];
    bit         model_vld [DEPTH];

    bias_loader dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .start_i   (start_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .rd_addr_i (rd_addr_i),
        .bias_o    (bias_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit known(input int a);
        return (a >= DEPTH) || model_vld[a];
    endfunction

    function automatic logic [7:0] exp_rd(input int a);
        return (a < DEPTH) ? model[a] : 8'h00;
    endfunction

    // Fill the trailing checksum slot: modulo-256 sum of the data bytes, optionally corrupted.
    function automatic blk_t with_sum(input blk_t d, input bit bad);
        blk_t r = d;
        int   s = 0;
        for (int i = 0; i < DEPTH; i++) s += d[i];
        r[DEPTH] = 8'((s % 256) + (bad ? 1 : 0));
        return r;
    endfunction

    // mode: 0 valid held, 1 toggling, 2 random. poke_at: issue start_i before that byte (-1 = never).
    task automatic run_load(input string nm, input blk_t d, input int mode, input int ra,
                            input int poke_at, input bit exp_err);
        int         idx = 0;
        int         guard = 0;
        bit         poked = 1'b0;
        bit         v;
        bit         chk;
        logic [7:0] exp;
        @(negedge clk_i);
        rd_addr_i = 10'(ra);
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s start: ready=%b done=%b err=%b want 1 0 0", nm, ready_o, done_o, err_o);
        end
        while (idx < NBYTES && guard < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            checks++;
            if (ready_o !== 1'b1) begin
                errors++;
                $display("FAIL %s ready_during_load: ready=%b want 1 at byte %0d", nm, ready_o, idx);
            end
            chk = known(ra);
            exp = exp_rd(ra);
            start_i = (idx == poke_at) && !poked;
            if (start_i) poked = 1'b1;
            valid_i = v;
            data_i  = v ? d[idx] : 8'($urandom);
            if (v) begin
                if (idx < DEPTH) begin
                    model[idx]     = d[idx];
                    model_vld[idx] = 1'b1;
                end
                idx++;
            end
            @(negedge clk_i);
            start_i = 1'b0;
            guard++;
            if (chk) begin
                checks++;
                if (bias_o !== exp) begin
                    errors++;
                    $display("FAIL %s read_during_load addr %0d: bias=%h want %h", nm, ra, bias_o, exp);
                end
            end
            if (idx < NBYTES) begin
                checks++;
                if (done_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_done: done=%b want 0 after %0d bytes", nm, done_o, idx);
                end
            end
        end
        valid_i = 1'b0;
        checks++;
        if (idx != NBYTES) begin
            errors++;
            $display("FAIL %s timeout: accepted %0d bytes want %0d", nm, idx, NBYTES);
        end
        checks++;
        if (done_o !== 1'b1 || ready_o !== 1'b0 || err_o !== exp_err) begin
            errors++;
            $display("FAIL %s end: done=%b ready=%b err=%b want 1 0 %b", nm, done_o, ready_o, err_o, exp_err);
        end
        valid_i = 1'b1;
        data_i  = 8'($urandom);
        repeat (2) @(negedge clk_i);
        valid_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || err_o !== exp_err) begin
            errors++;
            $display("FAIL %s done_hold: done=%b err=%b want 1 %b", nm, done_o, err_o, exp_err);
        end
    endtask

    task automatic check_reads(input string nm);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk_i);
            rd_addr_i = 10'(a);
            @(negedge clk_i);
            if (known(a)) begin
                checks++;
                if (bias_o !== exp_rd(a)) begin
                    errors++;
                    $display("FAIL %s read addr %0d: bias=%h want %h", nm, a, bias_o, exp_rd(a));
                end
            end
        end
        @(negedge clk_i);
        rd_addr_i = 10'h3FF;
        @(negedge clk_i);
        checks++;
        if (bias_o !== 8'h00) begin
            errors++;
            $display("FAIL %s read addr 1023: bias=%h want 00", nm, bias_o);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ready_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || bias_o !== 8'h00) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b err=%b bias=%h want 0 0 0 00",
                     ready_o, done_o, err_o, bias_o);
        end
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL idle: ready=%b done=%b want 0 0", ready_o, done_o);
        end
    endtask

    task automatic test_basic();
        blk_t d;
        for (int i = 0; i < DEPTH; i++) d[i] = 8'(i + 1);
        d = with_sum(d, 1'b0);
        checks++;
        if (CSUM && d[DEPTH] !== 8'h37) begin
            errors++;
            $display("FAIL model_sum: got %h want 37", d[DEPTH]);
        end
        run_load("basic", d, 0, 12, -1, 1'b0);
        check_reads("basic");
        run_load("toggle", d, 1, 3, -1, 1'b0);
        check_reads("toggle");
    endtask

    task automatic test_checksum_err();
        blk_t d;
        for (int i = 0; i < DEPTH; i++) d[i] = 8'($urandom);
        d[5] = 8'h55;
        d = with_sum(d, 1'b1);
        run_load("bad_sum", d, 2, 5, -1, CSUM);
        check_reads("bad_sum");
    endtask

    task automatic test_collision();
        blk_t d;
        for (int i = 0; i < DEPTH; i++) d[i] = 8'($urandom);
        d[5] = 8'hAA;
        d = with_sum(d, 1'b0);
        run_load("collide", d, 0, 5, -1, 1'b0);
        @(negedge clk_i);
        checks++;
        if (bias_o !== 8'hAA) begin
            errors++;
            $display("FAIL collide_after: bias=%h want aa", bias_o);
        end
    endtask

    task automatic test_start_mid_load();
        blk_t d;
        for (int i = 0; i < DEPTH; i++) d[i] = 8'($urandom);
        d = with_sum(d, 1'b0);
        run_load("start_mid", d, 2, 2, 3, 1'b0);
        check_reads("start_mid");
    endtask

    task automatic test_reset_mid_load();
        blk_t d;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            data_i  = 8'($urandom);
            model[i]     = data_i;
            model_vld[i] = 1'b1;
            @(negedge clk_i);
        end
        valid_i  = 1'b0;
        reset_ni = 1'b0;
        #1;
        checks++;
        if (bias_o !== 8'h00 || ready_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: bias=%h ready=%b done=%b want 00 0 0", bias_o, ready_o, done_o);
        end
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: done=%b ready=%b want 0 0", done_o, ready_o);
        end
        check_reads("partial");
        for (int i = 0; i < DEPTH; i++) d[i] = 8'(8'hF0 + i);
        d = with_sum(d, 1'b0);
        run_load("reload", d, 0, 7, -1, 1'b0);
        check_reads("reload");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model[i]     = 8'h00;
            model_vld[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_checksum_err();
        test_collision();
        test_start_mid_load();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
